pipelined_mul_unit: RTL and testbench

Parametrised successor to the fixed-latency M-extension multiplier path. Configurable operand width and pipeline depth; supports all four RV32M multiply ops (MUL/MULH/MULHSU/MULHU). The pipeline is elastic: bubbles collapse, and a writeback-port back-pressure handshake keeps results from being dropped. Sits beside execute_stage: fed from decode, drains to writeback, and exports an in-flight destination mask for hazard detection.

---
 rtl/constants_pkg.sv | 12 +
 rtl/structure_pkg.sv | 18 +
 rtl/mul_core_comb.sv | 33 +++
 rtl/pipelined_mul_unit.sv | 134 +++++++++++++
 tb/tb_pipelined_mul_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/constants_pkg.sv
// Shared encodings for the multiply unit.
// mul_op_t mirrors the RV32M funct3 low bits for MUL/MULH/MULHSU/MULHU.
package constants_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

endpackage

// File: rtl/structure_pkg.sv
// Inter-stage bundle for the multiply pipeline.
// Fields are sized for the widest supported config; users slice down.
package structure_pkg;

    import constants_pkg::*;

    localparam int MUL_XLEN_MAX = 64;
    localparam int MUL_TAG_MAX  = 8;
    localparam int MUL_PART_W   = 2 * MUL_XLEN_MAX + 2;

    typedef struct packed {
        logic                  valid;
        mul_op_t               op;
        logic [MUL_TAG_MAX-1:0] tag;
        logic [MUL_PART_W-1:0] partial;
    } mul_stage_t;

endpackage

// File: rtl/mul_core_comb.sv
// Signed/unsigned (XLEN+1)x(XLEN+1) product, purely combinational.
// Ports: op (MUL*), a=rs1, b=rs2 -> product (2*XLEN+2 bits, two's complement).
module mul_core_comb
    import constants_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN+1:0] product
);

    localparam int PW = 2 * XLEN + 2;

    logic                   a_signed;
    logic                   b_signed;
    logic signed [XLEN:0]   a_ext;
    logic signed [XLEN:0]   b_ext;
    logic signed [PW-1:0]   p;

    always_comb begin
        a_signed = (op == MULH) || (op == MULHSU);
        b_signed = (op == MULH);
        a_ext    = {a_signed & a[XLEN-1], a};
        b_ext    = {b_signed & b[XLEN-1], b};
        // Both operands sign-extend to PW; the PW-bit product is exact.
        p        = PW'(a_ext) * PW'(b_ext);
    end

    assign product = p;

endmodule

// File: rtl/pipelined_mul_unit.sv
// Elastic RV M-extension multiplier: bubble-collapsing pipeline with
// writeback back-pressure, memory-stage freeze, flush/kill and hazard mask.
// Ports: clk, rst (async active-low); in_* request from decode with
// stall_out; out_* result to writeback with out_ready; flush, kill_all,
// stall_in control; busy and inflight_mask status.
module pipelined_mul_unit
    import constants_pkg::*;
    import structure_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            in_op,
    input  logic [XLEN-1:0]       in_a,
    input  logic [XLEN-1:0]       in_b,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  flush,
    input  logic                  kill_all,
    input  logic                  stall_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_result,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  stall_out,
    output logic                  busy,
    output logic [2**TAG_W-1:0]   inflight_mask
);

    localparam int S  = STAGES - 1;
    localparam int PW = 2 * XLEN + 2;

    mul_stage_t        stg [STAGES];
    mul_stage_t        ins;
    mul_stage_t        last;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic              accept;
    logic [PW-1:0]     product;
    logic              unused_last;

    mul_core_comb #(
        .XLEN    (XLEN)
    ) u_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .product (product)
    );

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            vld[s] = stg[s].valid;
        end
    end

    // Ready ripples back from the writeback port; a stage may move if the
    // next one is empty or is itself moving.
    always_comb begin
        logic nxt;
        adv    = '0;
        nxt    = vld[S] & out_ready;
        adv[S] = nxt;
        for (int s = S - 1; s >= 0; s--) begin
            nxt    = vld[s] & (!vld[s+1] | nxt);
            adv[s] = nxt;
        end
    end

    assign accept = in_valid & !flush & !kill_all & !stall_in
                  & (!vld[0] | adv[0]);

    assign stall_out = in_valid & !flush & !kill_all & !accept;

    always_comb begin
        ins         = '0;
        ins.valid   = 1'b1;
        ins.op      = mul_op_t'(in_op);
        ins.tag     = MUL_TAG_MAX'(in_tag);
        ins.partial = MUL_PART_W'(product);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                stg[s] <= '0;
            end
        end else if (kill_all) begin
            for (int s = 0; s < STAGES; s++) begin
                stg[s].valid <= 1'b0;
            end
        end else if (!stall_in) begin
            for (int s = S; s >= 1; s--) begin
                if (adv[s-1]) begin
                    stg[s] <= stg[s-1];
                end else if (adv[s]) begin
                    stg[s].valid <= 1'b0;
                end
            end
            if (accept) begin
                stg[0] <= ins;
            end else if (adv[0]) begin
                stg[0].valid <= 1'b0;
            end
        end
    end

    assign last      = stg[S];
    assign out_valid = last.valid & !stall_in;
    assign out_tag   = last.tag[TAG_W-1:0];
    assign busy      = |vld;

    always_comb begin
        unique case (last.op)
            MUL:     out_result = last.partial[XLEN-1:0];
            default: out_result = last.partial[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        inflight_mask = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (stg[s].valid && stg[s].tag[TAG_W-1:0] != '0) begin
                inflight_mask[stg[s].tag[TAG_W-1:0]] = 1'b1;
            end
        end
    end

    assign unused_last = ^last;

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Directed bench for pipelined_mul_unit (XLEN=32, STAGES=3, TAG_W=5).
// Expected values are hand-computed constants and a tag-ordered queue.
module tb_pipelined_mul_unit;

    localparam int XLEN   = 32;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [1:0]          in_op;
    logic [XLEN-1:0]     in_a;
    logic [XLEN-1:0]     in_b;
    logic [TAG_W-1:0]    in_tag;
    logic                flush;
    logic                kill_all;
    logic                stall_in;
    logic                out_ready;
    logic                out_valid;
    logic [XLEN-1:0]     out_result;
    logic [TAG_W-1:0]    out_tag;
    logic                stall_out;
    logic                busy;
    logic [2**TAG_W-1:0] inflight_mask;

    int checks   = 0;
    int failures = 0;
    int nreq;
    int nres;
    int exp_q[$];
    int e;

    pipelined_mul_unit #(
        .XLEN          (XLEN),
        .STAGES        (STAGES),
        .TAG_W         (TAG_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .flush         (flush),
        .kill_all      (kill_all),
        .stall_in      (stall_in),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .stall_out     (stall_out),
        .busy          (busy),
        .inflight_mask (inflight_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; kill_all = 1'b0; stall_in = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stall_out", stall_out, 0);
        check("rst_mask", inflight_mask, 0);
        rst = 1'b1;
        tick;

        // MUL 7 * -3, latency and mask
        req(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        #1 check("t1_accept", stall_out, 0);
        tick; idle;
        #1 check("t1_mask5", inflight_mask[5], 1);
        check("t1_c1_ov", out_valid, 0);
        tick;
        #1 check("t1_c2_ov", out_valid, 0);
        tick;
        #1 check("t1_c3_ov", out_valid, 1);
        check("t1_result", out_result, 32'hFFFF_FFEB);
        check("t1_tag", out_tag, 5);
        tick;
        #1 check("t1_drained", busy, 0);

        // High-half ops back-to-back
        req(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
        tick;
        req(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        tick;
        req(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        tick; idle;
        #1 check("t2_mulh_ov", out_valid, 1);
        check("t2_mulh", out_result, 32'h4000_0000);
        check("t2_mulh_tag", out_tag, 1);
        tick;
        #1 check("t2_mulhsu_ov", out_valid, 1);
        check("t2_mulhsu", out_result, 32'hFFFF_FFFF);
        check("t2_mulhsu_tag", out_tag, 2);
        tick;
        #1 check("t2_mulhu_ov", out_valid, 1);
        check("t2_mulhu", out_result, 32'hFFFF_FFFE);
        check("t2_mulhu_tag", out_tag, 3);
        tick;
        #1 check("t2_drained", busy, 0);

        // Five requests with writeback back-pressure
        nreq = 0;
        nres = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (nreq < 5) req(OP_MUL, nreq + 1, 32'd10, 5'(nreq + 1));
            else idle;
            #1;
            if (cyc >= 3 && cyc <= 6) check("t3_stall_full", stall_out, 1);
            if (cyc == 3) check("t3_first_ov", out_valid, 1);
            if (out_valid && out_ready) begin
                check("t3_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("t3_tag", out_tag, e);
                    check("t3_result", out_result, e * 10);
                    nres++;
                end
            end
            if (in_valid && !stall_out) begin
                exp_q.push_back(nreq + 1);
                nreq++;
            end
            tick;
        end
        idle;
        out_ready = 1'b1;
        check("t3_count", nres, 5);
        check("t3_left", exp_q.size(), 0);
        #1 check("t3_drained", busy, 0);

        // Memory-stage freeze with two entries in flight
        req(OP_MUL, 32'd6, 32'd7, 5'd6);
        tick;
        req(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd7);
        tick;
        stall_in = 1'b1;
        req(OP_MUL, 32'd1, 32'd1, 5'd9);
        #1 check("t4_stall_out", stall_out, 1);
        check("t4_ov0", out_valid, 0);
        check("t4_busy", busy, 1);
        check("t4_mask", inflight_mask, 32'h0000_00C0);
        tick; idle;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_frozen_ov", out_valid, 0);
            check("t4_frozen_mask", inflight_mask, 32'h0000_00C0);
            tick;
        end
        stall_in = 1'b0;
        #1 check("t4_resume_ov0", out_valid, 0);
        tick;
        #1 check("t4_ov_a", out_valid, 1);
        check("t4_res_a", out_result, 42);
        check("t4_tag_a", out_tag, 6);
        tick;
        #1 check("t4_ov_b", out_valid, 1);
        check("t4_res_b", out_result, 1);
        check("t4_tag_b", out_tag, 7);
        tick;
        #1 check("t4_drained", busy, 0);

        // flush drops only this cycle's input
        req(OP_MUL, 32'd2, 32'd3, 5'd8);
        tick;
        req(OP_MUL, 32'd5, 32'd5, 5'd9);
        flush = 1'b1;
        #1 check("t5_flush_no_stall", stall_out, 0);
        tick;
        flush = 1'b0; idle;
        #1 check("t5_mask9", inflight_mask[9], 0);
        check("t5_mask8", inflight_mask[8], 1);
        tick;
        #1 check("t5_ov", out_valid, 1);
        check("t5_res", out_result, 6);
        check("t5_tag", out_tag, 8);
        tick;
        #1 check("t5_drained", busy, 0);

        // kill_all with three in flight plus a same-cycle request
        req(OP_MUL, 32'd1, 32'd2, 5'd10);
        tick;
        req(OP_MUL, 32'd1, 32'd3, 5'd11);
        tick;
        req(OP_MUL, 32'd1, 32'd4, 5'd12);
        tick;
        req(OP_MUL, 32'd1, 32'd5, 5'd13);
        kill_all = 1'b1;
        #1 check("t5_kill_no_stall", stall_out, 0);
        check("t5_kill_busy", busy, 1);
        check("t5_kill_mask", inflight_mask, 32'h0000_1C00);
        tick;
        kill_all = 1'b0; idle;
        #1 check("t5_killed_busy", busy, 0);
        check("t5_killed_mask", inflight_mask, 0);
        check("t5_killed_ov", out_valid, 0);

        // Asynchronous reset mid-flight
        req(OP_MUL, 32'd2, 32'd2, 5'd13);
        tick;
        req(OP_MUL, 32'd2, 32'd3, 5'd14);
        tick; idle;
        tick;
        #1 check("t6_pre_ov", out_valid, 1);
        check("t6_pre_busy", busy, 1);
        req(OP_MUL, 32'd9, 32'd9, 5'd15);
        #2 rst = 1'b0;
        #1 check("t6_rst_ov", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_stall", stall_out, 0);
        check("t6_rst_mask", inflight_mask, 0);
        idle;
        #1 rst = 1'b1;
        tick;
        req(OP_MUL, 32'd3, 32'd4, 5'd1);
        tick; idle;
        tick;
        tick;
        #1 check("t6_ov", out_valid, 1);
        check("t6_res", out_result, 12);
        check("t6_tag", out_tag, 1);
        tick;
        #1 check("t6_drained", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
